// File: rtl/ifmap_buf_sched_if.sv
// rtl/ifmap_buf_sched_if.sv - handshake bundle between layer control, loader, PE array and the ifmap scheduler
interface ifmap_buf_sched_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] cfg_tiles;
    logic             load_req;
    logic             load_bank;
    logic             load_done;
    logic             compute_start;
    logic             compute_bank;
    logic             complete;
    logic             free_ifmap_buffer;
    logic             busy;
    logic             layer_done;

    modport master (
        output start, cfg_tiles, load_done, complete,
        input  load_req, load_bank, compute_start, compute_bank,
               free_ifmap_buffer, busy, layer_done
    );

    modport slave (
        input  start, cfg_tiles, load_done, complete,
        output load_req, load_bank, compute_start, compute_bank,
               free_ifmap_buffer, busy, layer_done
    );
endinterface

// File: rtl/ifmap_buf_sched.sv
// rtl/ifmap_buf_sched.sv - ping-pong ifmap buffer scheduler overlapping tile loads with PE compute
module ifmap_buf_sched #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    ifmap_buf_sched_if.slave   bus
);
    typedef enum logic {S_IDLE, S_RUN} state_e;
    typedef enum logic [1:0] {B_EMPTY, B_LOADING, B_FULL, B_COMPUTING} bank_e;

    state_e           state_q, state_d;
    bank_e            bank_q [2];
    bank_e            bank_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0] loads_q, loads_d;
    logic [CNT_W-1:0] tiles_q, tiles_d;
    logic             load_req_q, load_req_d;
    logic             load_bank_q, load_bank_d;
    logic             compute_start_q, compute_start_d;
    logic             compute_bank_q, compute_bank_d;
    logic             free_q, free_d;
    logic             busy_q, busy_d;
    logic             layer_done_q, layer_done_d;
    logic             any_loading;
    logic             any_computing;
    logic             load_fire;
    logic             cmpl_fire;

    // Next-state: layer FSM, bank lifecycle and issue decisions.
    // Load issue looks only at registered state, so load_req always drops for
    // a cycle after load_done. Compute issue also sees a bank that is finishing
    // its fill this cycle, so compute_start follows load_done with no bubble.
    always_comb begin
        state_d         = state_q;
        bank_d          = bank_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        cfg_d           = cfg_q;
        loads_d         = loads_q;
        tiles_d         = tiles_q;
        load_req_d      = load_req_q;
        load_bank_d     = load_bank_q;
        compute_start_d = 1'b0;
        compute_bank_d  = compute_bank_q;
        free_d          = 1'b0;
        busy_d          = busy_q;
        layer_done_d    = 1'b0;
        any_loading     = (bank_q[0] == B_LOADING) || (bank_q[1] == B_LOADING);
        any_computing   = (bank_q[0] == B_COMPUTING) || (bank_q[1] == B_COMPUTING);
        load_fire       = 1'b0;
        cmpl_fire       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.cfg_tiles == '0) begin
                        layer_done_d = 1'b1;
                    end else begin
                        // Both banks start empty, so bank 0 is filled straight away.
                        state_d     = S_RUN;
                        busy_d      = 1'b1;
                        cfg_d       = bus.cfg_tiles;
                        bank_d[0]   = B_LOADING;
                        bank_d[1]   = B_EMPTY;
                        wr_ptr_d    = 1'b0;
                        rd_ptr_d    = 1'b0;
                        loads_d     = {{(CNT_W-1){1'b0}}, 1'b1};
                        tiles_d     = '0;
                        load_req_d  = 1'b1;
                        load_bank_d = 1'b0;
                    end
                end
            end
            S_RUN: begin
                load_fire = bus.load_done && any_loading;
                cmpl_fire = bus.complete && any_computing;

                if (load_fire) begin
                    bank_d[wr_ptr_q] = B_FULL;
                    wr_ptr_d         = ~wr_ptr_q;
                    load_req_d       = 1'b0;
                end else if (!any_loading && (loads_q < cfg_q) &&
                             (bank_q[wr_ptr_q] == B_EMPTY)) begin
                    bank_d[wr_ptr_q] = B_LOADING;
                    load_req_d       = 1'b1;
                    load_bank_d      = wr_ptr_q;
                    loads_d          = loads_q + 1'b1;
                end

                if (cmpl_fire) begin
                    bank_d[rd_ptr_q] = B_EMPTY;
                    free_d           = 1'b1;
                    rd_ptr_d         = ~rd_ptr_q;
                    tiles_d          = tiles_q + 1'b1;
                    if ((tiles_q + 1'b1) == cfg_q) begin
                        layer_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = S_IDLE;
                    end
                end else if (!any_computing && (bank_d[rd_ptr_q] == B_FULL)) begin
                    bank_d[rd_ptr_q] = B_COMPUTING;
                    compute_start_d  = 1'b1;
                    compute_bank_d   = rd_ptr_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any layer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            bank_q[0]       <= B_EMPTY;
            bank_q[1]       <= B_EMPTY;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            cfg_q           <= '0;
            loads_q         <= '0;
            tiles_q         <= '0;
            load_req_q      <= 1'b0;
            load_bank_q     <= 1'b0;
            compute_start_q <= 1'b0;
            compute_bank_q  <= 1'b0;
            free_q          <= 1'b0;
            busy_q          <= 1'b0;
            layer_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            bank_q          <= bank_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            cfg_q           <= cfg_d;
            loads_q         <= loads_d;
            tiles_q         <= tiles_d;
            load_req_q      <= load_req_d;
            load_bank_q     <= load_bank_d;
            compute_start_q <= compute_start_d;
            compute_bank_q  <= compute_bank_d;
            free_q          <= free_d;
            busy_q          <= busy_d;
            layer_done_q    <= layer_done_d;
        end
    end

    assign bus.load_req          = load_req_q;
    assign bus.load_bank         = load_bank_q;
    assign bus.compute_start     = compute_start_q;
    assign bus.compute_bank      = compute_bank_q;
    assign bus.free_ifmap_buffer = free_q;
    assign bus.busy              = busy_q;
    assign bus.layer_done        = layer_done_q;
endmodule

// File: tb/tb_ifmap_buf_sched.sv
// tb/tb_ifmap_buf_sched.sv - randomized-latency bench for ifmap_buf_sched with an event-timing reference model
module tb_ifmap_buf_sched;
    localparam int CNT_W = 8;
    localparam int UNK   = 1 << 29;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    ifmap_buf_sched_if #(.CNT_W(CNT_W)) bus ();

    ifmap_buf_sched #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".load_req"},      32'(bus.load_req),          0);
        chk({tag, ".load_bank"},     32'(bus.load_bank),         0);
        chk({tag, ".compute_start"}, 32'(bus.compute_start),     0);
        chk({tag, ".compute_bank"},  32'(bus.compute_bank),      0);
        chk({tag, ".free"},          32'(bus.free_ifmap_buffer), 0);
        chk({tag, ".busy"},          32'(bus.busy),              0);
        chk({tag, ".layer_done"},    32'(bus.layer_done),        0);
    endtask

    // Event model: with L = load_done cycle and C = complete cycle of tile k,
    //   load_req rise k   = start+1 (k=0), else max(L[k-1], C[k-2]) + 2
    //   compute_start k   = max(L[k]+1, C[k-1]+2)
    //   free k            = C[k]+1, layer_done = C[last]+1
    // Tiles alternate banks 0,1,0,1...
    task automatic run_layer(input int nt, input int dmin, input int dmax,
                             input int emin, input int emax, input string tag);
        int ld_c [256];
        int cp_c [256];
        int s, n_ld, n_cs, n_fr, ld_at, cp_at, drop_at, budget, expv;
        bit prev_lr, done_seen;
        for (int i = 0; i < 256; i++) begin
            ld_c[i] = UNK;
            cp_c[i] = UNK;
        end
        s = cyc;
        bus.start     = 1'b1;
        bus.cfg_tiles = CNT_W'(nt);
        step();
        bus.start = 1'b0;
        n_ld = 0; n_cs = 0; n_fr = 0;
        ld_at = -1; cp_at = -1; drop_at = -1;
        prev_lr = 1'b0; done_seen = 1'b0;
        budget = nt * (dmax + emax + 6) + 50;
        for (int t = 0; t < budget && !done_seen; t++) begin
            if (bus.load_req && !prev_lr) begin
                if (n_ld == 0) expv = s + 1;
                else expv = imax(ld_c[n_ld-1], (n_ld >= 2) ? cp_c[n_ld-2] : -UNK) + 2;
                chk({tag, ".load_rise_cyc"}, cyc, expv);
                chk({tag, ".load_bank"}, 32'(bus.load_bank), n_ld % 2);
                chk({tag, ".load_count_ok"}, 32'(n_ld < nt), 1);
                ld_at = cyc + int'($urandom_range(dmax, dmin));
                if (n_ld < 255) n_ld++;
            end
            if (drop_at == cyc) chk({tag, ".load_drop"}, 32'(bus.load_req), 0);
            if (bus.compute_start) begin
                expv = imax(ld_c[n_cs] + 1, (n_cs > 0) ? cp_c[n_cs-1] + 2 : -UNK);
                chk({tag, ".cstart_cyc"}, cyc, expv);
                chk({tag, ".cstart_bank"}, 32'(bus.compute_bank), n_cs % 2);
                cp_at = cyc + int'($urandom_range(emax, emin));
                if (n_cs < 255) n_cs++;
            end
            if (bus.free_ifmap_buffer) begin
                chk({tag, ".free_cyc"}, cyc, cp_c[n_fr] + 1);
                if (n_fr < 255) n_fr++;
            end
            if (bus.layer_done) begin
                chk({tag, ".done_cyc"}, cyc, cp_c[nt-1] + 1);
                chk({tag, ".done_busy"}, 32'(bus.busy), 0);
                chk({tag, ".done_frees"}, n_fr, nt);
                chk({tag, ".done_cstarts"}, n_cs, nt);
                done_seen = 1'b1;
            end else begin
                chk({tag, ".busy"}, 32'(bus.busy), 1);
            end
            prev_lr = bus.load_req;
            // A start mid-layer must be ignored, including its cfg_tiles.
            bus.start     = (cyc == s + 3);
            bus.cfg_tiles = CNT_W'(nt + 3);
            bus.load_done = (cyc == ld_at);
            if (cyc == ld_at) begin
                ld_c[n_ld-1] = cyc;
                drop_at      = cyc + 1;
            end
            bus.complete = (cyc == cp_at);
            if (cyc == cp_at) cp_c[n_cs-1] = cyc;
            step();
        end
        bus.start = 1'b0; bus.load_done = 1'b0; bus.complete = 1'b0;
        chk({tag, ".layer_done_seen"}, 32'(done_seen), 1);
        chk({tag, ".post_done_pulse"}, 32'(bus.layer_done), 0);
        chk({tag, ".post_busy"}, 32'(bus.busy), 0);
        chk({tag, ".post_load_req"}, 32'(bus.load_req), 0);
    endtask

    initial begin
        int s, nt, dm, em;
        rst = 1'b1;
        bus.start = 1'b1; bus.cfg_tiles = 8'd5;
        bus.load_done = 1'b1; bus.complete = 1'b1;
        step(); step();
        chk_quiet("reset");
        bus.start = 1'b0; bus.load_done = 1'b0; bus.complete = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk_quiet("after_reset");

        // Stray load_done / complete while idle.
        bus.complete = 1'b1; step();
        bus.complete = 1'b0; bus.load_done = 1'b1; step();
        bus.load_done = 1'b0;
        chk_quiet("spurious1"); step();
        chk_quiet("spurious2");

        // Zero-tile layer.
        bus.start = 1'b1; bus.cfg_tiles = '0; step();
        bus.start = 1'b0;
        chk("zero.layer_done", 32'(bus.layer_done), 1);
        chk("zero.load_req", 32'(bus.load_req), 0);
        chk("zero.busy", 32'(bus.busy), 0);
        step();
        chk("zero.layer_done_clr", 32'(bus.layer_done), 0);
        chk("zero.load_req2", 32'(bus.load_req), 0);

        // One tile: load 2 cycles, compute 4 cycles.
        run_layer(1, 2, 2, 4, 4, "single");
        // Fast loader, slow PE array.
        run_layer(4, 2, 2, 10, 10, "pingpong4");
        // load_done of bank1 coincides with complete of bank0.
        run_layer(2, 2, 2, 3, 3, "coincide");

        // Reset mid-layer while bank0 computes.
        s = cyc;
        bus.start = 1'b1; bus.cfg_tiles = 8'd3; step();
        bus.start = 1'b0;
        chk("abort.load_req", 32'(bus.load_req), 1);
        step();
        bus.load_done = 1'b1; step();
        bus.load_done = 1'b0;
        chk("abort.cstart", 32'(bus.compute_start), 1);
        chk("abort.cstart_cyc", cyc, s + 3);
        step();
        rst = 1'b1; step();
        rst = 1'b0;
        chk_quiet("abort.outputs");
        bus.complete = 1'b1; step();
        bus.complete = 1'b0;
        chk("abort.no_free1", 32'(bus.free_ifmap_buffer), 0);
        step();
        chk("abort.no_free2", 32'(bus.free_ifmap_buffer), 0);
        chk("abort.no_done", 32'(bus.layer_done), 0);
        run_layer(3, 1, 3, 1, 5, "after_abort");

        // Randomized layers.
        for (int i = 0; i < 6; i++) begin
            nt = int'($urandom_range(9, 1));
            dm = int'($urandom_range(6, 1));
            em = int'($urandom_range(8, 1));
            run_layer(nt, 1, dm, 1, em, "rand");
            repeat ($urandom_range(3, 0)) step();
        end

        // Largest legal tile count.
        run_layer(255, 1, 2, 1, 2, "max_tiles");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
